// File: rtl/test_pkg.sv
// rtl/test_pkg.sv - shared types and defaults for the receive test-pattern checker
package test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_RX       = 2'd2,
    ST_WAIT_EOF = 2'd3
  } state_t;

  localparam logic [15:0] SCR_INIT_DEFAULT  = 16'h55AA;
  localparam int          CNT_WIDTH_DEFAULT = 32;
  localparam int          WORD_CNT_WIDTH    = 16;

endpackage

// File: rtl/sata_scrambler.sv
// rtl/sata_scrambler.sv - x^16+x^15+x^13+x^4+1 scrambler, one 32-bit word per advance
module sata_scrambler #(
  parameter logic [15:0] G_INIT_VAL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic        i_en,
  output logic [31:0] o_data
);

  logic [15:0] r_lfsr;
  logic [47:0] w_step;

  // Oldest bit s[15] is emitted first; returns {next_state, word}.
  function automatic logic [47:0] f_step(input logic [15:0] s);
    logic [15:0] st;
    logic [31:0] w;
    st = s;
    w  = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = st[15];
      st   = {st[14:0], st[15] ^ st[14] ^ st[12] ^ st[3]};
    end
    return {st, w};
  endfunction

  assign w_step = f_step(r_lfsr);
  assign o_data = w_step[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= G_INIT_VAL;
    end else if (i_sof) begin
      r_lfsr <= G_INIT_VAL;
    end else if (i_en) begin
      r_lfsr <= w_step[47:32];
    end
  end

endmodule

// File: rtl/test_rx_chk.sv
// rtl/test_rx_chk.sv - MAC receive test-pattern checker with sticky error flags and statistics
// Optional TEST_RX_BITERR_EN adds the cnt_bit_err mismatched-bit counter.
module test_rx_chk
  import test_pkg::*;
#(
  parameter int          TEST_DATA_WIDTH  = 32,
  parameter logic [15:0] SCR_INIT         = SCR_INIT_DEFAULT,
  parameter bit          RESEED_PER_FRAME = 1'b0,
  parameter int          CNT_WIDTH        = CNT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
  input  logic                       mac_rx_valid,
  input  logic                       mac_rx_sof,
  input  logic                       mac_rx_eof,
  input  logic                       mac_rx_fr_good,
  input  logic                       mac_rx_fr_err,
  input  logic                       start,
  input  logic                       clr,
  input  logic [15:0]                frame_len_exp,
  output logic [TEST_DATA_WIDTH-1:0] test_data,
  output logic                       err,
  output logic                       err_cmp,
  output logic                       err_fr,
  output logic                       err_crc,
  output logic                       err_len,
  output logic [CNT_WIDTH-1:0]       cnt_frames,
  output logic [CNT_WIDTH-1:0]       cnt_bad_frames
`ifdef TEST_RX_BITERR_EN
  ,
  output logic [CNT_WIDTH-1:0]       cnt_bit_err
`endif
);

  localparam logic [CNT_WIDTH-1:0]      C_CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]      C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [WORD_CNT_WIDTH-1:0] C_WORD_MAX = '1;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [31:0]                 w_scr_word;
  logic                        w_scr_sof;
  logic                        w_scr_en;
  logic                        w_rx_entry;
  logic                        w_rx_word;
  logic                        w_frame_end;
  logic                        w_cmp_bad;
  logic                        w_fr_bad;
  logic                        w_crc_bad;
  logic                        w_len_bad;
  logic                        w_any_bad;
  logic [WORD_CNT_WIDTH-1:0]   w_len_cnt;
  logic [WORD_CNT_WIDTH-1:0]   r_word_cnt;
  logic                        r_frame_bad;
  logic                        r_err;
  logic                        r_err_cmp;
  logic                        r_err_fr;
  logic                        r_err_crc;
  logic                        r_err_len;
  logic [CNT_WIDTH-1:0]        r_cnt_frames;
  logic [CNT_WIDTH-1:0]        r_cnt_bad;

  sata_scrambler #(
    .G_INIT_VAL(SCR_INIT)
  ) u_scr (
    .clk   (clk),
    .rst   (rst),
    .i_sof (w_scr_sof),
    .i_en  (w_scr_en),
    .o_data(w_scr_word)
  );

  assign test_data = w_scr_word[TEST_DATA_WIDTH-1:0];

  // Frame checks; a late sof counts as a framing error only when the data itself matched.
  assign w_cmp_bad = w_rx_word & (mac_rx_data != test_data);
  assign w_fr_bad  = w_rx_word & ~w_cmp_bad &
                     (mac_rx_fr_err | (mac_rx_sof & (r_word_cnt != '0)));
  assign w_crc_bad = w_rx_word & mac_rx_eof & ~mac_rx_fr_good;
  assign w_len_cnt = (r_word_cnt == C_WORD_MAX) ? C_WORD_MAX : r_word_cnt + 16'd1;
  assign w_len_bad = w_frame_end & (frame_len_exp != '0) & (w_len_cnt != frame_len_exp);
  assign w_any_bad = w_cmp_bad | w_fr_bad | w_crc_bad | w_len_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_state_nxt = start ? ST_RX : ST_IDLE;
      end
      ST_RX: begin
        if (mac_rx_valid) begin
          if (mac_rx_eof) begin
            w_state_nxt = start ? ST_ARM : ST_IDLE;
          end else if (w_cmp_bad || w_fr_bad) begin
            w_state_nxt = ST_WAIT_EOF;
          end
        end
      end
      ST_WAIT_EOF: begin
        if (mac_rx_valid && mac_rx_eof) w_state_nxt = start ? ST_ARM : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_scr_sof   = 1'b0;
    w_scr_en    = 1'b0;
    w_rx_entry  = 1'b0;
    w_rx_word   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_scr_sof = start;
      end
      ST_ARM: begin
        w_rx_entry = start;
      end
      ST_RX: begin
        w_rx_word   = mac_rx_valid;
        w_scr_en    = mac_rx_valid;
        w_frame_end = mac_rx_valid & mac_rx_eof;
        w_scr_sof   = RESEED_PER_FRAME & w_frame_end & start;
      end
      ST_WAIT_EOF: begin
        w_scr_en    = mac_rx_valid;
        w_frame_end = mac_rx_valid & mac_rx_eof;
        w_scr_sof   = RESEED_PER_FRAME & w_frame_end & start;
      end
      default: begin
        w_scr_sof = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt  <= '0;
      r_frame_bad <= 1'b0;
    end else if (w_rx_entry) begin
      r_word_cnt  <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      if (w_scr_en && (r_word_cnt != C_WORD_MAX)) r_word_cnt <= r_word_cnt + 16'd1;
      if (w_any_bad) r_frame_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cmp <= 1'b0;
      r_err_fr  <= 1'b0;
      r_err_crc <= 1'b0;
      r_err_len <= 1'b0;
      r_err     <= 1'b0;
    end else if (clr) begin
      r_err_cmp <= 1'b0;
      r_err_fr  <= 1'b0;
      r_err_crc <= 1'b0;
      r_err_len <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_cmp_bad) r_err_cmp <= 1'b1;
      if (w_fr_bad)  r_err_fr  <= 1'b1;
      if (w_crc_bad) r_err_crc <= 1'b1;
      if (w_len_bad) r_err_len <= 1'b1;
      r_err <= r_err_cmp | r_err_fr | r_err_crc | r_err_len;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_frames <= '0;
      r_cnt_bad    <= '0;
    end else if (clr) begin
      r_cnt_frames <= '0;
      r_cnt_bad    <= '0;
    end else if (w_frame_end) begin
      if (r_cnt_frames != C_CNT_MAX) r_cnt_frames <= r_cnt_frames + C_CNT_ONE;
      if ((r_frame_bad || w_any_bad) && (r_cnt_bad != C_CNT_MAX)) r_cnt_bad <= r_cnt_bad + C_CNT_ONE;
    end
  end

  assign err            = r_err;
  assign err_cmp        = r_err_cmp;
  assign err_fr         = r_err_fr;
  assign err_crc        = r_err_crc;
  assign err_len        = r_err_len;
  assign cnt_frames     = r_cnt_frames;
  assign cnt_bad_frames = r_cnt_bad;

`ifdef TEST_RX_BITERR_EN
  logic [5:0]           r_pop;
  logic                 r_pop_vld;
  logic [CNT_WIDTH-1:0] r_bit_err;
  logic [CNT_WIDTH+6:0] w_bit_sum;

  function automatic logic [5:0] f_popcount(input logic [TEST_DATA_WIDTH-1:0] v);
    logic [5:0] pc;
    pc = '0;
    for (int i = 0; i < TEST_DATA_WIDTH; i++) pc = pc + 6'(v[i]);
    return pc;
  endfunction

  // Sum is computed wide so the saturation test never sees a wrapped value.
  assign w_bit_sum = {7'b0, r_bit_err} + {{(CNT_WIDTH + 1){1'b0}}, r_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pop     <= '0;
      r_pop_vld <= 1'b0;
      r_bit_err <= '0;
    end else if (clr) begin
      r_pop     <= '0;
      r_pop_vld <= 1'b0;
      r_bit_err <= '0;
    end else begin
      r_pop     <= f_popcount(mac_rx_data ^ test_data);
      r_pop_vld <= w_rx_word;
      if (r_pop_vld) begin
        r_bit_err <= (w_bit_sum > {7'b0, C_CNT_MAX}) ? C_CNT_MAX : w_bit_sum[CNT_WIDTH-1:0];
      end
    end
  end

  assign cnt_bit_err = r_bit_err;
`endif

endmodule

// File: tb/tb_test_rx_chk.sv
// tb/tb_test_rx_chk.sv - directed bench for test_rx_chk (reseeding/32-bit and continuous/4-bit instances)
module tb_test_rx_chk;
  import test_pkg::*;

  localparam logic [15:0] SEED = 16'h55AA;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic        rx_valid, rx_sof, rx_eof, fr_good, fr_err, start, clr;
  logic [15:0] len_exp;

  logic [31:0] a_test_data, a_cnt_frames, a_cnt_bad;
  logic        a_err, a_err_cmp, a_err_fr, a_err_crc, a_err_len;
  logic [31:0] b_test_data;
  logic [3:0]  b_cnt_frames, b_cnt_bad;
  logic        b_err, b_err_cmp, b_err_fr, b_err_crc, b_err_len;
`ifdef TEST_RX_BITERR_EN
  logic [31:0] a_bit_err;
  logic [3:0]  b_bit_err;
`endif

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_fail  = 0;
  logic [15:0] m_st;
  logic [47:0] m_tmp;

  always #5 clk = ~clk;

  test_rx_chk #(
    .TEST_DATA_WIDTH(32), .SCR_INIT(SEED), .RESEED_PER_FRAME(1'b1), .CNT_WIDTH(32)
  ) dut_a (
    .clk(clk), .rst(rst), .mac_rx_data(rx_data), .mac_rx_valid(rx_valid),
    .mac_rx_sof(rx_sof), .mac_rx_eof(rx_eof), .mac_rx_fr_good(fr_good),
    .mac_rx_fr_err(fr_err), .start(start), .clr(clr), .frame_len_exp(len_exp),
    .test_data(a_test_data), .err(a_err), .err_cmp(a_err_cmp), .err_fr(a_err_fr),
    .err_crc(a_err_crc), .err_len(a_err_len), .cnt_frames(a_cnt_frames),
    .cnt_bad_frames(a_cnt_bad)
`ifdef TEST_RX_BITERR_EN
    , .cnt_bit_err(a_bit_err)
`endif
  );

  test_rx_chk #(
    .TEST_DATA_WIDTH(32), .SCR_INIT(SEED), .RESEED_PER_FRAME(1'b0), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .mac_rx_data(rx_data), .mac_rx_valid(rx_valid),
    .mac_rx_sof(rx_sof), .mac_rx_eof(rx_eof), .mac_rx_fr_good(fr_good),
    .mac_rx_fr_err(fr_err), .start(start), .clr(clr), .frame_len_exp(len_exp),
    .test_data(b_test_data), .err(b_err), .err_cmp(b_err_cmp), .err_fr(b_err_fr),
    .err_crc(b_err_crc), .err_len(b_err_len), .cnt_frames(b_cnt_frames),
    .cnt_bad_frames(b_cnt_bad)
`ifdef TEST_RX_BITERR_EN
    , .cnt_bit_err(b_bit_err)
`endif
  );

  // Pattern as a bit sequence: x[n+16] = x[n]^x[n+1]^x[n+3]^x[n+12], state bit 15 holds x[0].
  function automatic logic [47:0] mexpand(input logic [15:0] s);
    logic        x [0:47];
    logic [31:0] w;
    logic [15:0] ns;
    for (int j = 0; j < 16; j++) x[j] = s[15-j];
    for (int n = 0; n < 32; n++) x[n+16] = x[n] ^ x[n+1] ^ x[n+3] ^ x[n+12];
    for (int i = 0; i < 32; i++) w[i] = x[i];
    for (int j = 0; j < 16; j++) ns[15-j] = x[32+j];
    return {ns, w};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; fr_err = 1'b0; clr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send_frame(input int nw, input int flip, input int frerr,
                            input logic good, input logic clr_eof);
    for (int i = 0; i < nw; i++) begin
      m_tmp    = mexpand(m_st);
      m_st     = m_tmp[47:32];
      rx_data  = m_tmp[31:0] ^ ((i == flip) ? 32'h1 : 32'h0);
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_eof   = (i == nw - 1);
      fr_err   = (i == frerr);
      fr_good  = good;
      clr      = clr_eof && (i == nw - 1);
      tick();
      if (i == flip && i != nw - 1) check("state_wait_eof", 64'(dut_a.r_state), 64'(ST_WAIT_EOF));
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; clr = 1'b0; len_exp = 16'd8;
    rx_data = '0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; fr_good = 1'b1; fr_err = 1'b0;
    repeat (3) tick();

    m_tmp = mexpand(SEED);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_flags", 64'({a_err_cmp, a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("rst_frames", 64'(a_cnt_frames), 64'd0);
    check("rst_bad", 64'(a_cnt_bad), 64'd0);
    check("rst_state", 64'(dut_a.r_state), 64'(ST_IDLE));
    check("rst_test_data", 64'(a_test_data), 64'(m_tmp[31:0]));

    rst = 1'b1;
    tick();
    start = 1'b1;
    idle(3);

    for (int f = 0; f < 3; f++) begin
      m_st = SEED;
      send_frame(8, -1, -1, 1'b1, 1'b0);
    end
    check("good_frames", 64'(a_cnt_frames), 64'd3);
    check("good_bad", 64'(a_cnt_bad), 64'd0);
    check("good_flags", 64'({a_err_cmp, a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("good_err", 64'(a_err), 64'd0);

    pulse_clr();
    m_st = SEED;
    send_frame(8, 3, -1, 1'b1, 1'b0);
    check("cmp_flag", 64'(a_err_cmp), 64'd1);
    check("cmp_other", 64'({a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("cmp_bad", 64'(a_cnt_bad), 64'd1);
    check("cmp_frames", 64'(a_cnt_frames), 64'd1);
    check("cmp_err", 64'(a_err), 64'd1);
`ifdef TEST_RX_BITERR_EN
    check("cmp_bit_err", 64'(a_bit_err), 64'd1);
`endif

    pulse_clr();
    check("clr_err", 64'(a_err), 64'd0);
    m_st = SEED;
    send_frame(8, -1, -1, 1'b0, 1'b0);
    check("crc_flag", 64'(a_err_crc), 64'd1);
    check("crc_other", 64'({a_err_cmp, a_err_fr, a_err_len}), 64'd0);
    check("crc_bad", 64'(a_cnt_bad), 64'd1);

    pulse_clr();
    m_st = SEED;
    send_frame(8, -1, 2, 1'b1, 1'b0);
    check("fr_flag", 64'(a_err_fr), 64'd1);
    check("fr_cmp", 64'(a_err_cmp), 64'd0);
    check("fr_crc_len", 64'({a_err_crc, a_err_len}), 64'd0);

    pulse_clr();
    m_st = SEED;
    send_frame(7, -1, -1, 1'b1, 1'b0);
    check("len_flag", 64'(a_err_len), 64'd1);
    check("len_other", 64'({a_err_cmp, a_err_fr, a_err_crc}), 64'd0);

    pulse_clr();
    len_exp = 16'd0;
    m_st = SEED;
    send_frame(7, -1, -1, 1'b1, 1'b0);
    check("len0_flags", 64'({a_err_cmp, a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("len0_frames", 64'(a_cnt_frames), 64'd1);
    check("len0_bad", 64'(a_cnt_bad), 64'd0);
    len_exp = 16'd8;

    m_st = SEED;
    for (int i = 0; i < 3; i++) begin
      m_tmp    = mexpand(m_st);
      m_st     = m_tmp[47:32];
      rx_data  = m_tmp[31:0] ^ ((i == 1) ? 32'h1 : 32'h0);
      rx_valid = 1'b1; rx_sof = (i == 0); rx_eof = 1'b0; fr_err = 1'b0; fr_good = 1'b1;
      tick();
    end
    check("pre_rst_cmp", 64'(a_err_cmp), 64'd1);
    rx_valid = 1'b0;
    rst = 1'b0;
    tick();
    m_tmp = mexpand(SEED);
    check("mid_rst_flags", 64'({a_err, a_err_cmp, a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("mid_rst_frames", 64'(a_cnt_frames), 64'd0);
    check("mid_rst_state", 64'(dut_a.r_state), 64'(ST_IDLE));
    check("mid_rst_test_data", 64'(a_test_data), 64'(m_tmp[31:0]));
    rst = 1'b1;
    idle(3);

    m_st = SEED;
    send_frame(8, -1, -1, 1'b1, 1'b0);
    send_frame(8, -1, -1, 1'b1, 1'b0);
    check("cont_flags", 64'({b_err, b_err_cmp, b_err_fr, b_err_crc, b_err_len}), 64'd0);
    check("cont_frames", 64'(b_cnt_frames), 64'd2);
    check("reseed_cmp", 64'(a_err_cmp), 64'd1);
    check("reseed_bad", 64'(a_cnt_bad), 64'd1);

    m_st = SEED;
    send_frame(8, -1, -1, 1'b0, 1'b1);
    check("clr_eof_flags", 64'({a_err, a_err_cmp, a_err_fr, a_err_crc, a_err_len}), 64'd0);
    check("clr_eof_frames", 64'(a_cnt_frames), 64'd0);
    check("clr_eof_bad", 64'(a_cnt_bad), 64'd0);
    check("clr_eof_b_frames", 64'(b_cnt_frames), 64'd0);

    for (int f = 0; f < 20; f++) begin
      send_frame(2, -1, -1, 1'b1, 1'b0);
      if (f == 14) check("sat_b_at_15", 64'(b_cnt_frames), 64'd15);
    end
    check("sat_b_frames", 64'(b_cnt_frames), 64'd15);
    check("sat_b_bad", 64'(b_cnt_bad), 64'd15);
    check("sat_a_frames", 64'(a_cnt_frames), 64'd20);
    check("sat_a_bad", 64'(a_cnt_bad), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
